// File: rtl/tdp_ram.sv
// True dual-port byte-enabled RAM with a post-reset zero-fill sweep.
// Same-address double writes are merged per byte lane; PRIO_B picks the winner on shared lanes.
module tdp_ram #(
  parameter int DATA_W   = 8,
  parameter int ADDR_W   = 8,
  parameter int RDW_MODE = 0,
  parameter int PRIO_B   = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              init_busy,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [DATA_W/8-1:0] a_be,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_rvalid,
  input  logic              b_en,
  input  logic              b_we,
  input  logic [DATA_W/8-1:0] b_be,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_rvalid,
  output logic              collision
);

  localparam int NB    = DATA_W / 8;
  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [0:0] ST_INIT = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]        state_reg;
  logic [ADDR_W-1:0] sweep_reg;
  logic [DATA_W-1:0] a_rdata_reg, b_rdata_reg;
  logic              a_rvalid_reg, b_rvalid_reg, collision_reg;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              run;
  logic              same_addr;
  logic [NB-1:0]     a_lane, b_lane, overlap, a_win, b_win;
  logic [DATA_W-1:0] a_old, b_old, a_final, b_final;

  assign run       = (state_reg == ST_RUN);
  assign init_busy = !run;
  assign same_addr = (a_addr == b_addr);

  // Lanes each port actually drives this cycle; nothing is written while sweeping.
  assign a_lane  = (run && a_en && a_we) ? a_be : '0;
  assign b_lane  = (run && b_en && b_we) ? b_be : '0;
  assign overlap = same_addr ? (a_lane & b_lane) : '0;

  assign a_old = mem[a_addr];
  assign b_old = mem[b_addr];

  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_lane
      assign a_win[gi] = a_lane[gi] && !(overlap[gi] && (PRIO_B != 0));
      assign b_win[gi] = b_lane[gi] && !(overlap[gi] && (PRIO_B == 0));
      // Word as it will be stored at each port's address once both ports' lanes land.
      assign a_final[gi*8 +: 8] = a_win[gi] ? a_wdata[gi*8 +: 8] :
                                  (same_addr && b_win[gi]) ? b_wdata[gi*8 +: 8] :
                                  a_old[gi*8 +: 8];
      assign b_final[gi*8 +: 8] = b_win[gi] ? b_wdata[gi*8 +: 8] :
                                  (same_addr && a_win[gi]) ? a_wdata[gi*8 +: 8] :
                                  b_old[gi*8 +: 8];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (!run) begin
      mem[sweep_reg] <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (a_win[i]) mem[a_addr][i*8 +: 8] <= a_wdata[i*8 +: 8];
        if (b_win[i]) mem[b_addr][i*8 +: 8] <= b_wdata[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= ST_INIT;
      sweep_reg     <= '0;
      a_rvalid_reg  <= 1'b0;
      b_rvalid_reg  <= 1'b0;
      a_rdata_reg   <= '0;
      b_rdata_reg   <= '0;
      collision_reg <= 1'b0;
    end else if (!run) begin
      sweep_reg     <= sweep_reg + 1'b1;
      if (sweep_reg == {ADDR_W{1'b1}}) state_reg <= ST_RUN;
      a_rvalid_reg  <= 1'b0;
      b_rvalid_reg  <= 1'b0;
      collision_reg <= 1'b0;
    end else begin
      a_rvalid_reg  <= a_en;
      b_rvalid_reg  <= b_en;
      collision_reg <= |overlap;
      // Write-first returns the merged word; cross-port and read-first see the old word.
      if (a_en) a_rdata_reg <= ((RDW_MODE != 0) && (a_lane != '0)) ? a_final : a_old;
      if (b_en) b_rdata_reg <= ((RDW_MODE != 0) && (b_lane != '0)) ? b_final : b_old;
    end
  end

  assign a_rdata   = a_rdata_reg;
  assign b_rdata   = b_rdata_reg;
  assign a_rvalid  = a_rvalid_reg;
  assign b_rvalid  = b_rvalid_reg;
  assign collision = collision_reg;

endmodule
